// File: rtl/true_dpram_param.sv
// Parametrised single-clock true dual-port RAM with self-clearing init, read-valid strobes,
// optional output register and A-wins write arbitration. Define TRUE_DPRAM_PARITY_EN for per-word even parity.
module true_dpram_param #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 3,
  parameter int OUT_REG    = 0,
  parameter int RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  init_done,
  input  logic                  en_a,
  input  logic                  en_b,
  input  logic                  we_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic                  qv_a,
  output logic                  qv_b,
`ifdef TRUE_DPRAM_PARITY_EN
  output logic                  parity_err_a,
  output logic                  parity_err_b,
`endif
  output logic                  collision
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef TRUE_DPRAM_PARITY_EN
  localparam int MW = DATA_WIDTH + 1;
`else
  localparam int MW = DATA_WIDTH;
`endif

  // Handshake: a port access is accepted on a rising edge when en_x && init_done; its result
  // appears with qv_x high exactly 1+OUT_REG cycles later, and qv_x is otherwise low.
  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [MW-1:0]           mem [DEPTH];
  logic [MW-1:0]           word_a, word_b;
  logic                    acc_a, acc_b, wr_a, wr_b, coll;
  logic [DATA_WIDTH-1:0]   q1_a, q1_b;
  logic                    qv1_a, qv1_b;

  function automatic logic [MW-1:0] pack_word(input logic [DATA_WIDTH-1:0] d);
`ifdef TRUE_DPRAM_PARITY_EN
    pack_word = {^d, d};
`else
    pack_word = d;
`endif
  endfunction

  assign acc_a  = en_a & init_done;
  assign acc_b  = en_b & init_done;
  assign wr_a   = acc_a & we_a;
  assign wr_b   = acc_b & we_b;
  assign coll   = wr_a & wr_b & (addr_a == addr_b);
  assign word_a = mem[addr_a];
  assign word_b = mem[addr_b];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else if (state == ST_INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
        state     <= ST_READY;
        init_done <= 1'b1;
      end
    end
  end

  // Storage is not reset; the INIT sweep clears it. Port A's write is issued last so it wins.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[cnt] <= pack_word(INIT_VALUE);
    end else begin
      if (wr_b && !coll) mem[addr_b] <= pack_word(data_b);
      if (wr_a)          mem[addr_a] <= pack_word(data_a);
    end
  end

  // Stage 1: reads see pre-edge contents, so cross-port read-during-write returns old data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q1_a      <= '0;
      q1_b      <= '0;
      qv1_a     <= 1'b0;
      qv1_b     <= 1'b0;
      collision <= 1'b0;
    end else begin
      qv1_a     <= acc_a;
      qv1_b     <= acc_b;
      collision <= coll;
      if (acc_a) q1_a <= (we_a && RDW_MODE == 0) ? data_a : word_a[DATA_WIDTH-1:0];
      if (acc_b) q1_b <= (we_b && RDW_MODE == 0) ? data_b : word_b[DATA_WIDTH-1:0];
    end
  end

`ifdef TRUE_DPRAM_PARITY_EN
  logic pe1_a, pe1_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pe1_a <= 1'b0;
      pe1_b <= 1'b0;
    end else begin
      pe1_a <= acc_a & ~we_a & (^word_a);
      pe1_b <= acc_b & ~we_b & (^word_b);
    end
  end
`endif

  generate
    if (OUT_REG != 0) begin : g_out_reg
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q_a  <= '0;
          q_b  <= '0;
          qv_a <= 1'b0;
          qv_b <= 1'b0;
`ifdef TRUE_DPRAM_PARITY_EN
          parity_err_a <= 1'b0;
          parity_err_b <= 1'b0;
`endif
        end else begin
          q_a  <= q1_a;
          q_b  <= q1_b;
          qv_a <= qv1_a;
          qv_b <= qv1_b;
`ifdef TRUE_DPRAM_PARITY_EN
          parity_err_a <= pe1_a;
          parity_err_b <= pe1_b;
`endif
        end
      end
    end else begin : g_no_out_reg
      assign q_a  = q1_a;
      assign q_b  = q1_b;
      assign qv_a = qv1_a;
      assign qv_b = qv1_b;
`ifdef TRUE_DPRAM_PARITY_EN
      assign parity_err_a = pe1_a;
      assign parity_err_b = pe1_b;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_true_dpram_param.sv
// Bench for true_dpram_param: two instances (latency 1 / new-data, latency 2 / old-data) share stimulus;
// a reference memory model feeds per-port expected queues that are popped as outputs appear.
module tb_true_dpram_param;

  localparam int DW = 12;
  localparam int AW = 3;
  localparam int EW = DW + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en_a = 1'b0, en_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] data_a = '0, data_b = '0;

  logic          id0, qv0_a, qv0_b, col0, pe0_a, pe0_b;
  logic          id1, qv1_a, qv1_b, col1, pe1_a, pe1_b;
  logic [DW-1:0] q0_a, q0_b, q1_a, q1_b;

  always #5 clk = ~clk;

  true_dpram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(0), .RDW_MODE(0), .INIT_VALUE('0)) dut0 (
    .clk(clk), .reset(reset), .init_done(id0),
    .en_a(en_a), .en_b(en_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .data_a(data_a), .data_b(data_b),
    .q_a(q0_a), .q_b(q0_b), .qv_a(qv0_a), .qv_b(qv0_b),
`ifdef TRUE_DPRAM_PARITY_EN
    .parity_err_a(pe0_a), .parity_err_b(pe0_b),
`endif
    .collision(col0)
  );

  true_dpram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(1), .RDW_MODE(1), .INIT_VALUE('0)) dut1 (
    .clk(clk), .reset(reset), .init_done(id1),
    .en_a(en_a), .en_b(en_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .data_a(data_a), .data_b(data_b),
    .q_a(q1_a), .q_b(q1_b), .qv_a(qv1_a), .qv_b(qv1_b),
`ifdef TRUE_DPRAM_PARITY_EN
    .parity_err_a(pe1_a), .parity_err_b(pe1_b),
`endif
    .collision(col1)
  );

`ifndef TRUE_DPRAM_PARITY_EN
  assign pe0_a = 1'b0;
  assign pe0_b = 1'b0;
  assign pe1_a = 1'b0;
  assign pe1_b = 1'b0;
`endif

  // Scoreboard: entries are {parity_err, qv, q}
  logic [EW-1:0] exp0a_q[$], exp0b_q[$], exp1a_q[$], exp1b_q[$];
  logic [DW-1:0] mem_m [8];
  logic          corrupt_m [8];
  logic [DW-1:0] last_q [2][2];
  int            init_cnt;
  int            total = 0;
  int            bad = 0;

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // d=0: new-data on own write; d=1: old-data on own write
  task automatic model_port(input int d, input int p, input logic acc, input logic en, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] wd, output logic [EW-1:0] e);
    logic [DW-1:0] q;
    logic          qv, pe;
    q  = last_q[d][p];
    qv = 1'b0;
    pe = 1'b0;
    if (acc && en) begin
      qv = 1'b1;
      if (we) q = (d == 1) ? mem_m[a] : wd;
      else begin
        q  = mem_m[a];
        pe = corrupt_m[a];
      end
      last_q[d][p] = q;
    end
    e = {pe, qv, q};
  endtask

  task automatic step(input logic ea, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                      input logic eb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    logic          acc, coll_e, id_e;
    logic [EW-1:0] e, o;
    en_a = ea; we_a = wa; addr_a = aa; data_a = da;
    en_b = eb; we_b = wb; addr_b = ab; data_b = db;
    acc = (init_cnt >= 8);
    model_port(0, 0, acc, ea, wa, aa, da, e); exp0a_q.push_back(e);
    model_port(0, 1, acc, eb, wb, ab, db, e); exp0b_q.push_back(e);
    model_port(1, 0, acc, ea, wa, aa, da, e); exp1a_q.push_back(e);
    model_port(1, 1, acc, eb, wb, ab, db, e); exp1b_q.push_back(e);
    coll_e = acc && ea && wa && eb && wb && (aa == ab);
    if (acc && eb && wb) begin mem_m[ab] = db; corrupt_m[ab] = 1'b0; end
    if (acc && ea && wa) begin mem_m[aa] = da; corrupt_m[aa] = 1'b0; end
    if (init_cnt < 8) init_cnt++;
    id_e = (init_cnt >= 8);
    @(posedge clk);
    @(negedge clk);
    check("init_done0", EW'(id0), EW'(id_e));
    check("init_done1", EW'(id1), EW'(id_e));
    check("collision0", EW'(col0), EW'(coll_e));
    check("collision1", EW'(col1), EW'(coll_e));
    e = (exp0a_q.size() > 0) ? exp0a_q.pop_front() : 'x; o = {pe0_a, qv0_a, q0_a}; check("port0a", o, e);
    e = (exp0b_q.size() > 0) ? exp0b_q.pop_front() : 'x; o = {pe0_b, qv0_b, q0_b}; check("port0b", o, e);
    e = (exp1a_q.size() > 0) ? exp1a_q.pop_front() : 'x; o = {pe1_a, qv1_a, q1_a}; check("port1a", o, e);
    e = (exp1b_q.size() > 0) ? exp1b_q.pop_front() : 'x; o = {pe1_b, qv1_b, q1_b}; check("port1b", o, e);
  endtask

  // Reset lands mid-cycle so the async clear is visible before any clock edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    en_a = 1'b0; en_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    #1;
    check("rst_q0", {q0_a, q0_b, qv0_a, qv0_b}, '0);
    check("rst_q1", {q1_a, q1_b, qv1_a, qv1_b}, '0);
    check("rst_ctl", {id0, id1, col0, col1, pe0_a, pe0_b, pe1_a, pe1_b}, '0);
    exp0a_q.delete(); exp0b_q.delete(); exp1a_q.delete(); exp1b_q.delete();
    for (int i = 0; i < 8; i++) begin
      mem_m[i] = '0;
      corrupt_m[i] = 1'b0;
    end
    for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) last_q[d][p] = '0;
    init_cnt = 0;
    exp1a_q.push_back('0);
    exp1b_q.push_back('0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    // INIT: reads presented on A are ignored; init_done must rise after exactly 8 cycles
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, AW'(i), '0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(7 - i), '0);
    // write A, read back on B
    step(1'b1, 1'b1, 3'd3, 12'hABC, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 3'd3, '0);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    // same-address write collision, then read back
    step(1'b1, 1'b1, 3'd5, 12'h111, 1'b1, 1'b1, 3'd5, 12'h222);
    step(1'b1, 1'b0, 3'd5, '0, 1'b1, 1'b0, 3'd5, '0);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    // cross-port read-during-write
    step(1'b1, 1'b1, 3'd2, 12'h055, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b1, 3'd2, 12'h0AA, 1'b1, 1'b0, 3'd2, '0);
    step(1'b1, 1'b0, 3'd2, '0, 1'b1, 1'b0, 3'd3, '0);
    step(1'b1, 1'b0, 3'd3, '0, 1'b1, 1'b0, 3'd3, '0);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    // random traffic on a narrow address range to provoke conflicts
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), DW'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), DW'($urandom));
`ifdef TRUE_DPRAM_PARITY_EN
    dut0.mem[1][DW] = ~dut0.mem[1][DW];
    dut1.mem[1][DW] = ~dut1.mem[1][DW];
    corrupt_m[1] = 1'b1;
    step(1'b1, 1'b0, 3'd1, '0, 1'b1, 1'b0, 3'd6, '0);
    step(1'b1, 1'b0, 3'd6, '0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
`endif
    // back-to-back reads interrupted by reset, then full re-init and sweep
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(i + 4), '0);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(i), '0);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
